// File: rtl/s1_pkg.sv
// s1_pkg: shared definitions for the S1 decode-stage hazard controller.
//   - Bit positions of the decode control word fields.
//   - insel_t: regfile write-data source select carried in the control word.
//   - mstate_t: memory access sequencer states.
//   - reg_mask(): one-hot register mask with r0 always excluded.
package s1_pkg;

  localparam int CW_JMP      = 3;
  localparam int CW_BRH      = 4;
  localparam int CW_MEM_REQ  = 8;
  localparam int CW_REG_WE   = 9;
  localparam int CW_INSEL_LO = 10;
  localparam int CW_INSEL_HI = 11;

  typedef enum logic [1:0] {
    INSEL_ALU       = 2'd0,
    INSEL_UPPER_IMM = 2'd1,
    INSEL_MEM       = 2'd2,
    INSEL_PC4       = 2'd3
  } insel_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_t;

  // r0 is never tracked, so its bit is always cleared in the mask.
  function automatic logic [31:0] reg_mask(input logic [4:0] idx);
    logic [31:0] m;
    m = 32'd1 << idx;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source priority mux for the regfile's single write port.
// Memory results always win; the ALU source is told to hold via o_alu_ready.
// Ports:
//   i_block              - forces the port idle (reset)
//   i_mem_valid/rd/data  - load writeback request (highest priority)
//   i_alu_valid/rd/data  - non-memory writeback request
//   o_we/o_rd/o_din      - regfile write port
//   o_alu_ready          - ALU request accepted this cycle
module wb_arbiter (
  input  logic        i_block,
  input  logic        i_mem_valid,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_we,
  output logic [4:0]  o_rd,
  output logic [31:0] o_din,
  output logic        o_alu_ready
);

  assign o_we        = ~i_block & (i_mem_valid | i_alu_valid);
  assign o_alu_ready = ~i_block & ~i_mem_valid;
  assign o_rd        = i_mem_valid ? i_mem_rd   : i_alu_rd;
  assign o_din       = i_mem_valid ? i_mem_data : i_alu_data;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the S1 decode stage.
// Tracks pending register writes, stalls/bubbles decode on RAW/WAW and
// memory-busy hazards, sequences the single outstanding memory access,
// bubbles decode after a redirect and arbitrates the regfile write port.
//
// state  | meaning
// M_IDLE | no memory access outstanding
// M_WAIT | one access in flight, waiting for mem_ack
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   dec_valid, dec_cw        - decode holds an instruction / its control word
//   dec_rs1, dec_rs2, dec_rd - register fields of the decoding instruction
//   redirect                 - taken branch/jump resolved in execute
//   mem_ack, mem_rdata       - memory completion and load data
//   alu_wb_*                 - non-memory writeback request / acceptance
//   mem_req                  - memory access in flight
//   fd_clk_en, dec_invalid   - decode advance enable / bubble into execute
//   reg_we, rd_addr, reg_din - regfile write port
module pipeline_ctrl
  import s1_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [11:0] dec_cw,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        redirect,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  output logic        mem_req,
  output logic        fd_clk_en,
  output logic        dec_invalid,
  output logic        reg_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] reg_din
);

  mstate_t     r_mstate;
  logic [31:1] r_sb;
  logic [4:0]  r_ld_rd;
  logic        r_ld_pend;
  logic [2:0]  r_flush_cnt;

  logic [31:0] w_sb;
  logic        w_cw_mem_req;
  logic        w_cw_reg_we;
  insel_t      w_cw_insel;
  logic        w_hazard;
  logic        w_flushing;
  logic        w_issue;
  logic        w_mem_wb;
  logic [31:0] w_sb_set;
  logic [31:0] w_sb_clr;
  logic        w_unused;

  // Bit 0 reads as zero, which folds the rs/rd != 0 qualifiers into the lookup.
  assign w_sb         = {r_sb, 1'b0};
  assign w_cw_mem_req = dec_cw[CW_MEM_REQ];
  assign w_cw_reg_we  = dec_cw[CW_REG_WE];
  assign w_cw_insel   = insel_t'(dec_cw[CW_INSEL_HI:CW_INSEL_LO]);

  assign w_hazard = dec_valid & (w_sb[dec_rs1] | w_sb[dec_rs2] |
                                 (w_cw_reg_we & w_sb[dec_rd]) |
                                 (w_cw_mem_req & (r_mstate == M_WAIT)));

  assign w_flushing = (r_flush_cnt != 3'd0) | redirect;
  assign w_issue    = dec_valid & ~w_hazard & ~w_flushing & ~rst;

  // A redirect kills whatever decode holds, so it overrides a stall.
  assign fd_clk_en   = ~rst & (w_flushing | ~w_hazard);
  assign dec_invalid = rst | w_flushing | w_hazard | ~dec_valid;
  assign mem_req     = ~rst & (r_mstate == M_WAIT);

  assign w_mem_wb = mem_ack & (r_mstate == M_WAIT) & r_ld_pend;

  wb_arbiter u_wb_arbiter (
    .i_block     (rst),
    .i_mem_valid (w_mem_wb),
    .i_mem_rd    (r_ld_rd),
    .i_mem_data  (mem_rdata),
    .i_alu_valid (alu_wb_valid),
    .i_alu_rd    (alu_wb_rd),
    .i_alu_data  (alu_wb_data),
    .o_we        (reg_we),
    .o_rd        (rd_addr),
    .o_din       (reg_din),
    .o_alu_ready (alu_wb_ready)
  );

  assign w_sb_set = (w_issue & w_cw_reg_we) ? reg_mask(dec_rd)  : 32'd0;
  assign w_sb_clr = reg_we                  ? reg_mask(rd_addr) : 32'd0;

  assign w_unused = ^{dec_cw[CW_JMP], dec_cw[CW_BRH], dec_cw[7:5], dec_cw[2:0],
                      w_sb_set[0], w_sb_clr[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb        <= '0;
      r_mstate    <= M_IDLE;
      r_ld_rd     <= '0;
      r_ld_pend   <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      // Set is OR'ed in after the clear so a same-bit collision keeps the bit set.
      r_sb <= (r_sb & ~w_sb_clr[31:1]) | w_sb_set[31:1];

      case (r_mstate)
        M_IDLE: begin
          if (w_issue && w_cw_mem_req) begin
            r_mstate  <= M_WAIT;
            r_ld_rd   <= dec_rd;
            r_ld_pend <= w_cw_reg_we && (w_cw_insel == INSEL_MEM);
          end
        end
        M_WAIT: begin
          if (mem_ack) begin
            r_mstate  <= M_IDLE;
            r_ld_pend <= 1'b0;
          end
        end
        default: r_mstate <= M_IDLE;
      endcase

      if (redirect)
        r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
      else if (r_flush_cnt != 3'd0)
        r_flush_cnt <= r_flush_cnt - 3'd1;
    end
  end

  // The WAW stall keeps an issuing rd from being pending, so no write can target it.
  a_sb_no_collision: assert property (@(posedge clk) disable iff (rst)
    (w_sb_set & w_sb_clr) == 32'd0);

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int F = 2;

  localparam logic [11:0] CW_NOP   = 12'h000;
  localparam logic [11:0] CW_LOAD  = 12'hB00;
  localparam logic [11:0] CW_STORE = 12'h100;
  localparam logic [11:0] CW_ADD   = 12'h200;

  logic        clk = 1'b0;
  logic        rst, dec_valid, redirect, mem_ack, alu_wb_valid;
  logic [11:0] dec_cw;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, alu_wb_rd;
  logic [31:0] mem_rdata, alu_wb_data;
  logic        alu_wb_ready, mem_req, fd_clk_en, dec_invalid, reg_we;
  logic [4:0]  rd_addr;
  logic [31:0] reg_din;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_cw(dec_cw),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .redirect(redirect),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_wb_valid(alu_wb_valid),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .mem_req(mem_req), .fd_clk_en(fd_clk_en), .dec_invalid(dec_invalid),
    .reg_we(reg_we), .rd_addr(rd_addr), .reg_din(reg_din)
  );

  typedef struct {
    bit          rst;
    bit          dv;
    logic [11:0] cw;
    logic [4:0]  rs1, rs2, rd;
    bit          redir;
    bit          ack;
    logic [31:0] rdata;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adata;
  } stim_t;

  // flags = {fd_clk_en, dec_invalid, reg_we, mem_req, alu_wb_ready}
  typedef struct {
    stim_t       s;
    logic [4:0]  flags;
    logic [4:0]  erd;
    logic [31:0] edin;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which registers are owed a write, whether a memory
  // access is outstanding and where its data goes, and bubbles still owed.
  bit pend[32];
  bit m_busy;
  int m_ld_rd;
  bit m_ld_wr;
  int m_bub;

  vec_t vq[$];
  int   alu_q[$];

  function automatic stim_t st(bit r, bit dv, logic [11:0] cw, int rs1, int rs2, int rd,
                               bit redir, bit ack, logic [31:0] rdata,
                               bit av, int ard, logic [31:0] adata);
    stim_t s;
    s.rst = r; s.dv = dv; s.cw = cw;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.redir = redir; s.ack = ack; s.rdata = rdata;
    s.av = av; s.ard = 5'(ard); s.adata = adata;
    return s;
  endfunction

  task automatic add_vec(input stim_t s, input logic [4:0] f, input int erd, input logic [31:0] edin);
    vec_t v;
    v.s = s; v.flags = f; v.erd = 5'(erd); v.edin = edin;
    vq.push_back(v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_busy = 1'b0; m_ld_rd = 0; m_ld_wr = 1'b0; m_bub = 0;
  endtask

  // One clock: drive at negedge, check against the model 1ns later, advance model at posedge.
  task automatic cycle(input stim_t s, output bit rdy, output bit iss,
                       output logic [4:0] act, output logic [4:0] act_rd, output logic [31:0] act_din);
    bit haz, fl, mwb, we;
    logic [4:0]  wa, exp;
    logic [31:0] wd;
    haz = 0; fl = 0; mwb = 0; we = 0; wa = '0; wd = '0; rdy = 0; iss = 0;
    @(negedge clk);
    rst = s.rst; dec_valid = s.dv; dec_cw = s.cw;
    dec_rs1 = s.rs1; dec_rs2 = s.rs2; dec_rd = s.rd;
    redirect = s.redir; mem_ack = s.ack; mem_rdata = s.rdata;
    alu_wb_valid = s.av; alu_wb_rd = s.ard; alu_wb_data = s.adata;
    #1;
    act     = {fd_clk_en, dec_invalid, reg_we, mem_req, alu_wb_ready};
    act_rd  = rd_addr;
    act_din = reg_din;
    if (s.rst) begin
      exp = 5'b01000;
    end else begin
      haz = s.dv && ((s.rs1 != 0 && pend[s.rs1]) || (s.rs2 != 0 && pend[s.rs2]) ||
                     (s.cw[9] && s.rd != 0 && pend[s.rd]) || (s.cw[8] && m_busy));
      fl  = (m_bub > 0) || s.redir;
      iss = s.dv && !haz && !fl;
      mwb = s.ack && m_busy && m_ld_wr;
      we  = mwb || s.av;
      wa  = mwb ? 5'(m_ld_rd) : s.ard;
      wd  = mwb ? s.rdata : s.adata;
      rdy = !mwb;
      exp = {fl || !haz, fl || haz || !s.dv, we, m_busy, rdy};
    end
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_flags t=%0t got=%b want=%b", $time, act, exp);
    end
    if (!s.rst) begin
      n_tests++;
      if ({act_rd, act_din} !== {wa, wd}) begin
        n_fail++;
        $display("FAIL model_wport t=%0t got=%0d/%h want=%0d/%h", $time, act_rd, act_din, wa, wd);
      end
    end
    @(posedge clk);
    if (s.rst) begin
      model_reset();
    end else begin
      if (we && wa != 0) pend[wa] = 1'b0;
      if (iss && s.cw[9] && s.rd != 0) pend[s.rd] = 1'b1;
      if (m_busy) begin
        if (s.ack) m_busy = 1'b0;
      end else if (iss && s.cw[8]) begin
        m_busy  = 1'b1;
        m_ld_rd = int'(s.rd);
        m_ld_wr = s.cw[9] && (s.cw[11:10] == 2'd2);
      end
      if (s.redir) m_bub = F - 1;
      else if (m_bub > 0) m_bub--;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit rdy, iss;
    logic [4:0]  act, act_rd;
    logic [31:0] act_din;
    logic [11:0] cw_tab[7];
    bit          hold;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;
    stim_t       s;

    rst = 1; dec_valid = 0; dec_cw = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    redirect = 0; mem_ack = 0; mem_rdata = '0; alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    model_reset();

    // RAW on load
    add_vec(st(1,1,CW_LOAD,1,2,5, 0,0,0, 0,0,0),          5'b01000, 0, 0);
    add_vec(st(0,1,CW_LOAD,1,2,5, 0,0,0, 0,0,0),          5'b10001, 0, 0);
    add_vec(st(0,1,CW_ADD, 5,0,6, 0,0,0, 0,0,0),          5'b01011, 0, 0);
    add_vec(st(0,1,CW_ADD, 5,0,6, 0,0,0, 0,0,0),          5'b01011, 0, 0);
    add_vec(st(0,1,CW_ADD, 5,0,6, 0,1,32'hDEADBEEF, 0,0,0), 5'b01110, 5, 32'hDEADBEEF);
    add_vec(st(0,1,CW_ADD, 5,0,6, 0,0,0, 0,0,0),          5'b10001, 0, 0);
    // Writeback collision
    add_vec(st(0,1,CW_LOAD,0,0,3, 0,0,0, 1,6,32'h66),     5'b10101, 6, 32'h66);
    add_vec(st(0,1,CW_ADD, 1,2,7, 0,0,0, 0,0,0),          5'b10011, 0, 0);
    add_vec(st(0,0,CW_NOP, 0,0,0, 0,1,32'h33, 1,7,32'h77), 5'b11110, 3, 32'h33);
    add_vec(st(0,0,CW_NOP, 0,0,0, 0,0,0, 1,7,32'h77),     5'b11101, 7, 32'h77);
    add_vec(st(0,1,CW_ADD, 3,7,8, 0,0,0, 0,0,0),          5'b10001, 0, 0);
    // Back-to-back memory
    add_vec(st(0,1,CW_STORE,1,2,0, 0,0,0, 0,0,0),         5'b10001, 0, 0);
    add_vec(st(0,1,CW_LOAD,1,0,9, 0,0,0, 0,0,0),          5'b01011, 0, 0);
    add_vec(st(0,1,CW_LOAD,1,0,9, 0,1,32'h12, 0,0,0),     5'b01011, 0, 0);
    add_vec(st(0,1,CW_LOAD,1,0,9, 0,0,0, 0,0,0),          5'b10001, 0, 0);
    add_vec(st(0,0,CW_NOP, 0,0,0, 0,0,0, 0,0,0),          5'b11011, 0, 0);
    add_vec(st(0,0,CW_NOP, 0,0,0, 0,1,32'h99, 0,0,0),     5'b11110, 9, 32'h99);
    // Redirect during hazard stall
    add_vec(st(0,1,CW_ADD, 8,0,10, 0,0,0, 0,0,0),         5'b01001, 0, 0);
    add_vec(st(0,1,CW_ADD, 8,0,10, 1,0,0, 0,0,0),         5'b11001, 0, 0);
    add_vec(st(0,1,CW_ADD, 8,0,10, 0,0,0, 0,0,0),         5'b11001, 0, 0);
    add_vec(st(0,1,CW_ADD, 8,0,10, 0,0,0, 0,0,0),         5'b01001, 0, 0);
    add_vec(st(0,1,CW_ADD, 8,0,10, 0,0,0, 1,8,32'h88),    5'b01101, 8, 32'h88);
    add_vec(st(0,1,CW_ADD, 8,10,10, 0,0,0, 0,0,0),        5'b10001, 0, 0);
    // r0 handling
    add_vec(st(0,1,CW_ADD, 1,2,0, 0,0,0, 0,0,0),          5'b10001, 0, 0);
    add_vec(st(0,1,CW_ADD, 0,0,0, 0,0,0, 1,0,32'h5),      5'b10101, 0, 32'h5);
    // Reset while an access is in flight
    add_vec(st(0,1,CW_LOAD,1,2,11, 0,0,0, 0,0,0),         5'b10001, 0, 0);
    add_vec(st(1,0,CW_NOP, 0,0,0, 0,0,0, 0,0,0),          5'b01000, 0, 0);
    add_vec(st(0,0,CW_NOP, 0,0,0, 0,1,32'hBAD, 0,0,0),    5'b11001, 0, 0);
    add_vec(st(0,1,CW_ADD, 10,11,12, 0,0,0, 0,0,0),       5'b10001, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].s, rdy, iss, act, act_rd, act_din);
      n_tests++;
      if (act !== vq[i].flags) begin
        n_fail++;
        $display("FAIL vec%0d_flags got=%b want=%b", i, act, vq[i].flags);
      end
      if (vq[i].flags[2]) begin
        n_tests++;
        if ({act_rd, act_din} !== {vq[i].erd, vq[i].edin}) begin
          n_fail++;
          $display("FAIL vec%0d_wport got=%0d/%h want=%0d/%h", i, act_rd, act_din, vq[i].erd, vq[i].edin);
        end
      end
    end

    // Randomized traffic; the ALU source only writes back registers it owes.
    cw_tab[0] = CW_LOAD; cw_tab[1] = CW_STORE; cw_tab[2] = CW_ADD; cw_tab[3] = CW_NOP;
    cw_tab[4] = 12'hE08; cw_tab[5] = 12'h300; cw_tab[6] = 12'h010;
    cycle(st(1,0,CW_NOP,0,0,0, 0,0,0, 0,0,0), rdy, iss, act, act_rd, act_din);
    alu_q.delete();
    hold = 0; hold_rd = '0; hold_data = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold && alu_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        hold      = 1;
        hold_rd   = 5'(alu_q.pop_front());
        hold_data = $urandom;
      end
      s = st(0, $urandom_range(0, 3) != 0, cw_tab[$urandom_range(0, 6)],
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15) == 0,
             m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
             $urandom, hold, int'(hold_rd), hold_data);
      cycle(s, rdy, iss, act, act_rd, act_din);
      if (iss && s.cw[9] && !(s.cw[8] && s.cw[11:10] == 2'd2))
        alu_q.push_back(int'(s.rd));
      if (hold && rdy) hold = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the S1 decode stage. Keeps a per-register pending-write scoreboard and stalls or bubbles decode on RAW/WAW hazards. Sequences the single outstanding memory access and arbitrates the regfile's one write port between ALU and memory results. Drives the decode stage's `clk_en`, `invalid`, `reg_we`, `rd_addr` and `reg_din` inputs.

## Interface
- `FLUSH_CYCLES`, default 2: cycles decode is bubbled after a redirect (1..7).
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `dec_valid  in  1`: decode holds an instruction.
- `dec_cw  in  12`: decode control word (bit 3 JMP, 4 BRH, 8 MEM_REQ, 9 REG_WE, 11:10 REG_INSEL; 2 = MEM).
- `dec_rs1`, `dec_rs2`, `dec_rd  in  5`: source and destination fields of the decoding instruction.
- `redirect  in  1`: execute resolved a taken branch or jump this cycle.
- `mem_ack  in  1`: memory completes the outstanding access (load data valid).
- `mem_rdata  in  32`: load data, valid with `mem_ack`.
- `alu_wb_valid  in  1`, `alu_wb_rd  in  5`, `alu_wb_data  in  32`: non-memory writeback request.
- `alu_wb_ready  out  1`: ALU writeback accepted this cycle. The source holds its request while this is low.
- `mem_req  out  1`: memory access in flight (level).
- `fd_clk_en  out  1`: fetch/decode advance enable (to decode `clk_en`).
- `dec_invalid  out  1`: bubble into execute (to decode `invalid`).
- `reg_we  out  1`, `rd_addr  out  5`, `reg_din  out  32`: regfile write port.

## Operation
- `hazard` = `dec_valid` and any of the following:
  - `sb[dec_rs1]` with `rs1` ≠ 0;
  - `sb[dec_rs2]` with `rs2` ≠ 0;
  - REG_WE and `sb[dec_rd]` with `rd` ≠ 0 (WAW);
  - MEM_REQ and `mstate` == M_WAIT.
- `flushing` = `flush_cnt` ≠ 0 or `redirect`.
- `issue` = `dec_valid` and not `hazard` and not `flushing`.
- Enable and bubble outputs:
  - `fd_clk_en` = `flushing` or not `hazard`.
  - `dec_invalid` = `flushing` or `hazard` or not `dec_valid`.
  - Redirect dominates a stall.
- Scoreboard `sb[31:1]`, with `sb[0]` hardwired 0:
  - Set on issue when REG_WE and `rd` ≠ 0.
  - Cleared when `reg_we` writes that register.
  - If set and clear hit the same bit in one cycle, set wins. WAW stall makes this unreachable; assert it anyway.
- Memory FSM, `M_IDLE` → `M_WAIT`:
  - Transition on issue with MEM_REQ.
  - On that transition, latch `ld_rd` = `dec_rd` and `ld_pend` = REG_WE and (REG_INSEL == MEM).
  - `M_WAIT` → `M_IDLE` on `mem_ack`.
  - `mem_req` = (`mstate` == M_WAIT).
  - `mem_ack` in `M_IDLE` is ignored.
- Writeback arbiter (memory has priority):
  - `mem_wb` = `mem_ack` and `M_WAIT` and `ld_pend`.
  - `alu_wb_ready` = not `mem_wb`.
  - `reg_we` = `mem_wb` or `alu_wb_valid`.
  - Address/data: `ld_rd`/`mem_rdata` if `mem_wb`, else `alu_wb_rd`/`alu_wb_data`.
  - A write to r0 is forwarded to the port unchanged (the regfile ignores it); the scoreboard is untouched.
- Flush counter:
  - `redirect` loads `flush_cnt` = `FLUSH_CYCLES` − 1.
  - Decrements to 0 while nonzero.
  - A redirect during a flush reloads the counter.
  - Does not affect the scoreboard or memory FSM, since only unissued instructions are killed.

## Timing
- Reset values while `rst` is high and on the following edge:
  - `sb` = 0, `mstate` = M_IDLE, `ld_pend` = 0, `flush_cnt` = 0.
  - Outputs forced: `fd_clk_en` = 0, `dec_invalid` = 1, `reg_we` = 0, `mem_req` = 0, `alu_wb_ready` = 0.
  - Reset mid-access abandons it; a later `mem_ack` is ignored.
- Hazard, `fd_clk_en`, `dec_invalid` and the writeback port are combinational from current state plus inputs. There is no registered output latency.
- A writeback in cycle N clears the scoreboard bit at the N edge. A dependent instruction stalls in N and issues in N+1; there is no write-to-read bypass.
- A memory op issued in cycle N gives `mem_req` from N+1 through the `mem_ack` cycle inclusive. The next memory op can issue no earlier than the cycle after ack.
- `redirect` in cycle N bubbles decode in N through N+`FLUSH_CYCLES`−1.

## Structure
- Package `s1_pkg` holds:
  - Control-word bit index constants (`CW_JMP`, `CW_BRH`, `CW_MEM_REQ`, `CW_REG_WE`, `CW_INSEL` range).
  - The `insel_t` enum (ALU, UPPER_IMM, MEM, PC4).
  - The `mstate_t` enum.
- One sub-module, `wb_arbiter`: the combinational two-source priority mux plus the ready output. Scoreboard, FSM and flush counter stay in the top.

## Test plan
- RAW on load:
  - Issue load with `rd`=5, then `add` with `rs1`=5.
  - Required: `add` stalls (`fd_clk_en`=0, `dec_invalid`=1) until the `mem_ack` cycle; issues the cycle after.
  - Required: `reg_we`=1, `rd_addr`=5, `reg_din`=`mem_rdata` on the ack cycle.
- Writeback collision: `mem_ack` for `rd`=3 coincides with `alu_wb_valid` for `rd`=7.
  - Required: memory wins, `alu_wb_ready`=0.
  - Required: `rd`=7 writes the next cycle; both scoreboard bits clear.
- Back-to-back memory: store then load.
  - Required: the load stalls until the cycle after the store's ack.
  - Required: `mem_req` is continuous except for that gap.
- Redirect during hazard stall with `FLUSH_CYCLES`=2.
  - Required: `fd_clk_en`=1 and `dec_invalid`=1 for exactly 2 cycles.
  - Required: no issue in those cycles; scoreboard unchanged.
- r0 handling: an instruction with `rd`=0 issues, then a reader of r0.
  - Required: no stall; `sb[0]` stays 0.
- Reset in `M_WAIT`: assert `rst`, then `mem_ack`.
  - Required: all outputs at reset values; no `reg_we`; `mstate`=M_IDLE.
